// File: rtl/up_packet_link_pkg.sv
// Shared types and constants for the uP-side byte-serial link.
//   NOS_READ_BYTES  : bytes in one command packet from the uP
//   NOS_WRITE_BYTES : bytes in one reply returned to the uP
//   byte_t          : one link byte
//   link_state_t    : link FSM state encoding (also exported for debug)
//   cmd_packet_t    : parallel command handed to the register bank
package up_packet_link_pkg;

  localparam int NOS_READ_BYTES  = 6;
  localparam int NOS_WRITE_BYTES = 8;

  localparam int MAX_BYTES = (NOS_READ_BYTES > NOS_WRITE_BYTES) ? NOS_READ_BYTES : NOS_WRITE_BYTES;
  // Wide enough to hold the terminal count, so the counter never wraps.
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int RD_IDX_W  = $clog2(NOS_READ_BYTES);
  localparam int WR_IDX_W  = $clog2(NOS_WRITE_BYTES);

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_H1_HI  = 4'd1,
    RX_H1_LO  = 4'd2,
    CMD_ISSUE = 4'd3,
    CMD_WAIT  = 4'd4,
    TX_DRIVE  = 4'd5,
    TX_H1_HI  = 4'd6,
    TX_H1_LO  = 4'd7,
    DONE      = 4'd8
  } link_state_t;

  typedef struct packed {
    byte_t       code;
    byte_t       reg_addr;
    logic [31:0] data;
  } cmd_packet_t;

  // Little-endian assembly: b0 is the least significant byte.
  function automatic logic [31:0] le_word(input byte_t b0, input byte_t b1,
                                          input byte_t b2, input byte_t b3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/up_packet_link_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (chain clears to 0)
//   d_i    : asynchronous input
//   q_o    : synchronised output, STAGES cycles of latency
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/up_packet_link.sv
// uP-side byte-serial link: collects a command packet from the uP over a
// two-wire handshake, issues it to the register bank, then streams the
// 8-byte data+status reply back and signals completion on uP_ack.
// Ports:
//   clk, reset              : system clock, asynchronous active-low reset
//   async_uP_start          : uP transaction frame (asynchronous)
//   async_uP_handshake_1    : uP strobe/ack (asynchronous)
//   uP_data_out [7:0]       : byte from the uP
//   uP_ack                  : transaction complete
//   uP_handshake_2          : FPGA strobe/ack
//   uP_data_in [7:0]        : byte to the uP
//   cmd_valid / cmd_ready   : command handshake to the register bank
//   cmd_code, cmd_reg_addr, cmd_data : command packet fields
//   rsp_valid, rsp_data, rsp_status  : one-cycle reply strobe and payload
//   timeout_err             : sticky timeout flag, cleared at next frame start
//   dbg_state_o             : current FSM state
// Handshake semantics: cmd_valid rises only when every command field is
// final; the fields are held stable while cmd_valid is high and the command
// transfers on the first clock edge with cmd_valid && cmd_ready, after
// which cmd_valid drops. rsp_valid is a one-cycle strobe with no back-pressure,
// honoured only while the link is waiting for a reply.
module up_packet_link
  import up_packet_link_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic [7:0]  uP_data_out,
  output logic        uP_ack,
  output logic        uP_handshake_2,
  output logic [7:0]  uP_data_in,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic [7:0]  cmd_reg_addr,
  output logic [31:0] cmd_data,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic [31:0] rsp_status,
  output logic        timeout_err,
  output link_state_t dbg_state_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic start_s;
  logic h1_s;
  logic start_prev_q;
  logic start_rise;

  link_state_t state_q;
  link_state_t prev_state_q;
  logic [TMO_W-1:0] tmo_q;
  logic tmo_hit;

  logic [CNT_W-1:0] cnt_q;
  logic tx_phase_q;
  byte_t [NOS_READ_BYTES-1:0]  rx_q;
  byte_t [NOS_WRITE_BYTES-1:0] rsp_q;
  logic  hs2_q;
  logic  ack_q;
  logic  cmd_valid_q;
  logic  err_q;
  byte_t data_in_q;

  cmd_packet_t pkt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (async_uP_start),
    .q_o    (start_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_h1 (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (async_uP_handshake_1),
    .q_o    (h1_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start_s;
    end
  end

  assign start_rise = start_s & ~start_prev_q;

  // Dwell counter: restarts whenever the state differs from last cycle's.
  // The hit is masked on the first cycle of a new state so a count left
  // over from the previous state can never abort the new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_state_q <= IDLE;
      tmo_q        <= '0;
    end else begin
      prev_state_q <= state_q;
      if (state_q == IDLE || state_q != prev_state_q) begin
        tmo_q <= '0;
      end else if (!tmo_hit) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  assign tmo_hit = (state_q == prev_state_q) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_phase_q  <= 1'b0;
      rx_q        <= '0;
      rsp_q       <= '0;
      hs2_q       <= 1'b0;
      ack_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      data_in_q   <= '0;
    end else if (state_q != IDLE && (!start_s || tmo_hit)) begin
      // Frame dropped or a wait stalled too long. This is also the normal
      // exit from DONE once the uP releases start.
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_phase_q  <= 1'b0;
      hs2_q       <= 1'b0;
      ack_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q <= RX_H1_HI;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        RX_H1_HI: begin
          if (h1_s) begin
            rx_q[cnt_q[RD_IDX_W-1:0]] <= uP_data_out;
            hs2_q   <= 1'b1;
            state_q <= RX_H1_LO;
          end
        end
        RX_H1_LO: begin
          if (!h1_s) begin
            hs2_q <= 1'b0;
            if (cnt_q == CNT_W'(NOS_READ_BYTES - 1)) begin
              cnt_q       <= '0;
              cmd_valid_q <= 1'b1;
              state_q     <= CMD_ISSUE;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= RX_H1_HI;
            end
          end
        end
        CMD_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= CMD_WAIT;
          end
        end
        CMD_WAIT: begin
          if (rsp_valid) begin
            rsp_q      <= {rsp_status, rsp_data};
            tx_phase_q <= 1'b0;
            state_q    <= TX_DRIVE;
          end
        end
        TX_DRIVE: begin
          // Two cycles: put the byte on the bus, then raise the strobe,
          // so the uP never sees hs2 before the data has settled.
          if (!tx_phase_q) begin
            data_in_q  <= rsp_q[cnt_q[WR_IDX_W-1:0]];
            tx_phase_q <= 1'b1;
          end else begin
            hs2_q      <= 1'b1;
            tx_phase_q <= 1'b0;
            state_q    <= TX_H1_HI;
          end
        end
        TX_H1_HI: begin
          if (h1_s) begin
            hs2_q   <= 1'b0;
            state_q <= TX_H1_LO;
          end
        end
        TX_H1_LO: begin
          if (!h1_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NOS_WRITE_BYTES - 1)) begin
              ack_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= TX_DRIVE;
            end
          end
        end
        DONE: begin
          // Held until the uP drops start (handled by the abort branch).
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pkt.code     = rx_q[0];
  assign pkt.reg_addr = rx_q[1];
  assign pkt.data     = le_word(rx_q[2], rx_q[3], rx_q[4], rx_q[5]);

  assign cmd_code       = pkt.code;
  assign cmd_reg_addr   = pkt.reg_addr;
  assign cmd_data       = pkt.data;
  assign cmd_valid      = cmd_valid_q;
  assign uP_ack         = ack_q;
  assign uP_handshake_2 = hs2_q;
  assign uP_data_in     = data_in_q;
  assign timeout_err    = err_q;
  assign dbg_state_o    = state_q;

endmodule
